// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath core: opcodes, FSM states, widths.
// Imported by the ALU and the core.
package datapath_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_MOV  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_ILLD = 4'hD;
  localparam logic [3:0] OP_ILLE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  function automatic int instr_w(input int data_w, input int reg_aw);
    return 4 + reg_aw + data_w;
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU; the core registers result and flags.
// carry is add carry-out or subtract borrow, zero for all other ops.
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (op)
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: {carry, result} = {1'b0, a} - {1'b0, b};
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: result = a << 1;
      OP_SHR: result = a >> 1;
      OP_MOV: result = a;
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/datapath_core.sv
// Multi-cycle accumulator-style core: fetch/decode/exec/writeback FSM
// with single-step support, sticky illegal-op flag and debug read port.
module datapath_core
  import datapath_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int REG_AW = 2,
  parameter int ADDR_W = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              imem_req,
  output logic [ADDR_W-1:0]                 imem_addr,
  input  logic                              imem_ack,
  input  logic [instr_w(DATA_W,REG_AW)-1:0] imem_rdata,
  input  logic                              step_mode,
  input  logic                              step,
  input  logic [REG_AW-1:0]                 dbg_addr,
  output logic [DATA_W-1:0]                 dbg_data,
  output logic [ADDR_W-1:0]                 pc_o,
  output logic [2:0]                        state_o,
  output logic                              flag_z,
  output logic                              flag_c,
  output logic                              halted,
  output logic                              illegal
);

  localparam int INSTR_W = instr_w(DATA_W, REG_AW);
  localparam int NREG    = 2 ** REG_AW;

  state_t              state, nxt;
  logic [ADDR_W-1:0]   pc;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   regs [NREG];
  logic [DATA_W-1:0]   alu_q;

  logic [3:0]          op;
  logic [REG_AW-1:0]   rd, ra, rb;
  logic [DATA_W-1:0]   field;
  logic                is_alu, jump_taken;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry, alu_zero;

  assign op    = ir[INSTR_W-1 -: 4];
  assign rd    = ir[DATA_W +: REG_AW];
  assign field = ir[DATA_W-1:0];
  assign ra    = field[2*REG_AW-1:REG_AW];
  assign rb    = field[REG_AW-1:0];

  assign is_alu     = (op >= OP_ADD) && (op <= OP_MOV);
  assign jump_taken = (op == OP_JMP) ||
                      ((op == OP_JZ) && (regs[rd] == '0));

  datapath_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (regs[ra]),
    .b      (regs[rb]),
    .result (alu_res),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_FETCH:  if (imem_ack) nxt = ST_DECODE;
      ST_DECODE: begin
        if (op == OP_LDI)       nxt = ST_WB;
        else if (is_alu)        nxt = ST_EXEC;
        else if (op == OP_HALT) nxt = ST_HALT;
        else nxt = step_mode ? ST_WAIT : ST_FETCH;
      end
      ST_EXEC:   nxt = ST_WB;
      ST_WB:     nxt = step_mode ? ST_WAIT : ST_FETCH;
      ST_WAIT:   if (step || !step_mode) nxt = ST_FETCH;
      ST_HALT:   nxt = ST_HALT;
      default:   nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      ir      <= '0;
      alu_q   <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (state == ST_FETCH && imem_ack) begin
        ir <= imem_rdata;
        pc <= pc + 1'b1;
      end
      if (state == ST_DECODE) begin
        if (jump_taken) pc <= ADDR_W'(field);
        if (op == OP_ILLD || op == OP_ILLE) illegal <= 1'b1;
      end
      if (state == ST_EXEC) begin
        alu_q  <= alu_res;
        flag_z <= alu_zero;
        if (op == OP_ADD || op == OP_SUB) flag_c <= alu_carry;
      end
      if (state == ST_WB)
        regs[rd] <= (op == OP_LDI) ? field : alu_q;
    end
  end

  // request drops combinationally while reset is held
  assign imem_req  = (state == ST_FETCH) && !rst;
  assign imem_addr = pc;
  assign pc_o      = pc;
  assign state_o   = state;
  assign halted    = (state == ST_HALT);
  assign dbg_data  = regs[dbg_addr];

endmodule

// File: tb/tb_datapath_core.sv
// Directed bench for datapath_core: instruction table plus
// hand sequences for fetch stall, step mode, reset and PC wrap.
module tb_datapath_core;
  import datapath_pkg::*;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int PW = 8;
  localparam int IW = 4 + AW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;
  logic [PW-1:0] pc_o;
  logic [2:0]    state_o;
  logic          flag_z, flag_c, halted, illegal;

  datapath_core #(.DATA_W(DW), .REG_AW(AW), .ADDR_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .step_mode  (step_mode),
    .step       (step),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .pc_o       (pc_o),
    .state_o    (state_o),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] imem [256];
  int ack_delay = 0;
  int wcnt = 0;

  // memory answers after ack_delay waiting FETCH cycles
  always @(negedge clk) begin
    if (rst || !imem_req) begin
      imem_ack <= 1'b0;
      wcnt     <= 0;
    end else if (wcnt >= ack_delay) begin
      imem_ack   <= 1'b1;
      imem_rdata <= imem[imem_addr];
    end else begin
      imem_ack <= 1'b0;
      wcnt     <= wcnt + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [3:0] op,
                                       input logic [1:0] rd,
                                       input logic [3:0] f);
    return {op, rd, f};
  endfunction

  task automatic rd_reg(input int r, output int v);
    dbg_addr = AW'(r);
    #1;
    v = int'(dbg_data);
  endtask

  task automatic exec_one(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!(state_o == 3'd0 || state_o == 3'd5) && cyc < 20);
  endtask

  task automatic wait_state(input int s, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (int'(state_o) != s && cyc < 20);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = '0;
  endtask

  typedef struct {
    int            addr;
    logic [IW-1:0] ins;
    int            cyc;
    int            rsel;
    int            rval;
    int            z;
    int            c;
    int            ill;
    int            pc;
  } vec_t;

  vec_t tv[$];

  task automatic add(input int a, input logic [3:0] op,
                     input logic [1:0] rd, input logic [3:0] f,
                     input int cyc, input int rs, input int rv,
                     input int z, input int c, input int il,
                     input int pc);
    vec_t v;
    v.addr = a; v.ins = mk(op, rd, f); v.cyc = cyc;
    v.rsel = rs; v.rval = rv; v.z = z; v.c = c;
    v.ill = il; v.pc = pc;
    tv.push_back(v);
  endtask

  initial begin
    int cyc, v;

    // program executed in table order (addr, op, rd, field, cycles,
    // reg checked, its value, z, c, illegal, pc after)
    add( 0, 4'hC, 0, 4'h3, 2, 0, 0,  0, 0, 0,  3);
    add( 3, 4'h1, 1, 4'h5, 3, 1, 5,  0, 0, 0,  4);
    add( 4, 4'h1, 2, 4'h3, 3, 2, 3,  0, 0, 0,  5);
    add( 5, 4'h2, 3, 4'h6, 4, 3, 8,  0, 0, 0,  6);
    add( 6, 4'h1, 1, 4'hF, 3, 1, 15, 0, 0, 0,  7);
    add( 7, 4'h1, 2, 4'h1, 3, 2, 1,  0, 0, 0,  8);
    add( 8, 4'h2, 0, 4'h6, 4, 0, 0,  1, 1, 0,  9);
    add( 9, 4'h3, 0, 4'h9, 4, 0, 2,  0, 1, 0, 10);
    add(10, 4'h4, 3, 4'h6, 4, 3, 1,  0, 1, 0, 11);
    add(11, 4'h6, 3, 4'h5, 4, 3, 0,  1, 1, 0, 12);
    add(12, 4'h7, 3, 4'h8, 4, 3, 14, 0, 1, 0, 13);
    add(13, 4'h8, 3, 4'hC, 4, 3, 12, 0, 1, 0, 14);
    add(14, 4'h9, 3, 4'hC, 4, 3, 6,  0, 1, 0, 15);
    add(15, 4'hA, 0, 4'hC, 4, 0, 6,  0, 1, 0, 16);
    add(16, 4'h2, 2, 4'hA, 4, 2, 2,  0, 0, 0, 17);
    add(17, 4'h3, 2, 4'hA, 4, 2, 0,  1, 0, 0, 18);
    add(18, 4'hE, 0, 4'h0, 2, 2, 0,  1, 0, 1, 19);
    add(19, 4'h1, 1, 4'h3, 3, 1, 3,  1, 0, 1, 20);
    add(20, 4'hB, 1, 4'h0, 2, 1, 3,  1, 0, 1, 21);
    add(21, 4'h5, 3, 4'h1, 4, 3, 7,  0, 0, 1, 22);
    add(22, 4'h0, 0, 4'h0, 2, 3, 7,  0, 0, 1, 23);

    // reset values, sampled while reset is held
    clear_imem();
    foreach (tv[i]) imem[tv[i].addr] = tv[i].ins;
    imem[23] = mk(4'hF, 2'd0, 4'h0);
    #2 rst = 1'b1;
    #1;
    chk("rst_state", int'(state_o), 0);
    chk("rst_pc", int'(pc_o), 0);
    chk("rst_req", int'(imem_req), 0);
    chk("rst_flags", int'({flag_z, flag_c, illegal, halted}), 0);
    for (int r = 0; r < 4; r++) begin
      rd_reg(r, v);
      chk($sformatf("rst_r%0d", r), v, 0);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    foreach (tv[i]) begin
      exec_one(cyc);
      chk($sformatf("v%0d_cycles", i), cyc, tv[i].cyc);
      rd_reg(tv[i].rsel, v);
      chk($sformatf("v%0d_r%0d", i, tv[i].rsel), v, tv[i].rval);
      chk($sformatf("v%0d_z", i), int'(flag_z), tv[i].z);
      chk($sformatf("v%0d_c", i), int'(flag_c), tv[i].c);
      chk($sformatf("v%0d_ill", i), int'(illegal), tv[i].ill);
      chk($sformatf("v%0d_pc", i), int'(pc_o), tv[i].pc);
    end

    exec_one(cyc);
    chk("halt_cycles", cyc, 2);
    chk("halt_state", int'(state_o), 5);
    chk("halt_flag", int'(halted), 1);
    chk("halt_req", int'(imem_req), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("halt_stay", int'(state_o), 5);
    chk("halt_pc", int'(pc_o), 24);

    // taken JZ loops back to address 0
    clear_imem();
    imem[0] = mk(4'h1, 2'd1, 4'h0);
    imem[1] = mk(4'hB, 2'd1, 4'h0);
    do_reset();
    exec_one(cyc);
    chk("loop_ldi_cycles", cyc, 3);
    exec_one(cyc);
    chk("loop_jz_cycles", cyc, 2);
    chk("loop_pc", int'(pc_o), 0);
    chk("loop_addr", int'(imem_addr), 0);
    chk("loop_req", int'(imem_req), 1);

    // stalled fetch holds request and address
    clear_imem();
    imem[0] = mk(4'h1, 2'd2, 4'h9);
    ack_delay = 3;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_state", k), int'(state_o), 0);
      chk($sformatf("stall%0d_req", k), int'(imem_req), 1);
      chk($sformatf("stall%0d_addr", k), int'(imem_addr), 0);
    end
    ack_delay = 0;
    exec_one(cyc);
    chk("stall_tail_cycles", cyc, 3);
    rd_reg(2, v);
    chk("stall_r2", v, 9);

    // reset during a stalled fetch
    exec_one(cyc);
    exec_one(cyc);
    chk("pre_rst_pc", int'(pc_o), 3);
    ack_delay = 10;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_state", int'(state_o), 0);
    #3 rst = 1'b1;
    #1;
    chk("midrst_req", int'(imem_req), 0);
    chk("midrst_pc", int'(pc_o), 0);
    chk("midrst_r2", int'(dut.regs[2]), 0);
    ack_delay = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("postrst_req", int'(imem_req), 1);
    chk("postrst_addr", int'(imem_addr), 0);
    exec_one(cyc);
    chk("postrst_cycles", cyc, 3);
    rd_reg(2, v);
    chk("postrst_r2", v, 9);

    // single-step mode
    clear_imem();
    imem[0] = mk(4'h1, 2'd1, 4'h7);
    imem[1] = mk(4'h2, 2'd3, 4'h5);
    step_mode = 1'b1;
    do_reset();
    wait_state(4, cyc);
    chk("step_ldi_cycles", cyc, 3);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("park%0d", k), int'(state_o), 4);
    end
    chk("park_pc", int'(pc_o), 1);
    rd_reg(1, v);
    chk("step_r1", v, 7);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    chk("step_release", int'(state_o), 0);
    wait_state(2, cyc);
    chk("step_to_exec", cyc, 2);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    chk("exec_step_ignored", int'(state_o), 3);
    @(posedge clk); #1;
    chk("wb_to_wait", int'(state_o), 4);
    repeat (3) @(posedge clk);
    #1;
    chk("wait_hold", int'(state_o), 4);
    step_mode = 1'b0;
    @(posedge clk); #1;
    chk("mode_clear_release", int'(state_o), 0);
    rd_reg(3, v);
    chk("step_r3", v, 14);

    // PC wraps from 0xFF to 0x00
    clear_imem();
    do_reset();
    for (int k = 0; k < 255; k++) exec_one(cyc);
    chk("wrap_pc_ff", int'(pc_o), 255);
    exec_one(cyc);
    chk("wrap_cycles", cyc, 2);
    chk("wrap_pc_00", int'(pc_o), 0);
    chk("wrap_addr", int'(imem_addr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/datapath_core.md
DATAPATH_CORE -- requirements
Module: datapath_core

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_W, 4, register/ALU width
- REG_AW, 2, register address width (2^REG_AW registers)
- ADDR_W, 8, instruction address width
- Constraint: DATA_W >= 2*REG_AW
- Derived: INSTR_W = 4+REG_AW+DATA_W
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; the core uses one clock only.
- rst, in, 1, asynchronous active-high reset.
- imem_req, out, 1, fetch request.
- imem_addr, out, ADDR_W, fetch address.
- imem_ack, in, 1, fetch data valid.
- imem_rdata, in, INSTR_W, fetched instruction.
- step_mode, in, 1, 1 = single-step mode.
- step, in, 1, single-step advance pulse.
- dbg_addr, in, REG_AW, debug register select.
- dbg_data, out, DATA_W, combinational read of register dbg_addr.
- pc_o, out, ADDR_W, current PC.
- state_o, out, 3, FSM state code.
- flag_z, out, 1, zero flag.
- flag_c, out, 1, carry/borrow flag.
- halted, out, 1, core in HALT.
- illegal, out, 1, sticky: undefined opcode seen.

Function
REQ-003 Instruction fields:
- op = instr[INSTR_W-1 -: 4]
- rd = next REG_AW bits
- field = low DATA_W bits
- ra = field[2*REG_AW-1:REG_AW]
- rb = field[REG_AW-1:0]
REQ-004 Opcodes:
- 0 NOP; 1 LDI rd=field; 2 ADD rd=ra+rb; 3 SUB rd=ra-rb; 4 AND; 5 OR; 6 XOR; 7 NOT rd=~ra; 8 SHL rd=ra<<1; 9 SHR rd=ra>>1 (logical); A MOV rd=ra.
- B JZ: if reg[rd]==0, PC=zero-extended field.
- C JMP: PC=zero-extended field.
- F HALT.
- D, E: execute as NOP and set illegal.
REQ-005 FSM state codes: FETCH=0, DECODE=1, EXEC=2, WB=3, WAIT_STEP=4, HALT=5.
REQ-006 FETCH:
- imem_req=1 with imem_addr=PC, both held stable until imem_ack.
- On ack: latch IR, PC=PC+1 (wraps 2^ADDR_W-1 -> 0), go to DECODE.
REQ-007 DECODE transitions:
- LDI -> WB.
- ALU ops (2-A) -> EXEC.
- NOP, JZ, JMP, D, E -> WAIT_STEP if step_mode, else FETCH; PC overwrite for a taken jump occurs here.
- HALT -> HALT.
REQ-008 EXEC: ALU result and flags registered in one cycle, then WB.
REQ-009 WB: register write happens in this cycle; next state is WAIT_STEP if step_mode, else FETCH.
REQ-010 Latencies with imem_ack in the first FETCH cycle: ALU op 4 cycles, LDI 3, NOP/jump 2.
REQ-011 Flags:
- ADD: C = carry out.
- SUB: C = borrow (ra<rb).
- Z updated by every ALU op (2-A) from the DATA_W-bit result.
- C changed only by ADD/SUB.
- LDI and jumps leave both flags unchanged.
REQ-012 WAIT_STEP: leave to FETCH on a cycle with step=1; step in any other state is ignored.
REQ-013 Clearing step_mode while in WAIT_STEP releases to FETCH on the next cycle.
REQ-014 HALT: absorbing until reset; halted=1 and imem_req=0.
REQ-015 Register r0 is an ordinary writable register.
REQ-016 Same-register operands (ra==rb==rd) read old values and write the new result.

Reset
REQ-017 rst asserted (asynchronous) sets:
- state=FETCH, PC=0, IR=0
- all registers=0
- flag_z=0, flag_c=0, illegal=0, halted=0
- imem_req=0 in the same cycle
REQ-018 Reset mid-fetch abandons the request; the first post-reset fetch is from address 0.

Structure
REQ-019 Package datapath_pkg holds: opcode constants, FSM state enum/codes, INSTR_W derivation function.
REQ-020 ALU is sub-module datapath_alu (combinational: op, a, b -> result, carry, zero); registering happens in datapath_core.

Verification
REQ-021 Basic ALU: LDI r1,5; LDI r2,3; ADD r3,r1,r2 -> r3=8, Z=0, C=0, each instruction at the REQ-010 latency.
REQ-022 Wrap: LDI r1,F; LDI r2,1; ADD r0,r1,r2 -> r0=0, Z=1, C=1; then SUB r0,r2,r1 -> r0=2, C=1.
REQ-023 Loop: LDI r1,0; JZ r1,0x0 -> fetch returns to address 0; JZ with r1=3 falls through to PC+1.
REQ-024 Fetch and PC boundaries:
- imem_ack delayed 3 cycles -> imem_addr stable and no IR change.
- PC 0xFF + fetch -> PC 0x00.
REQ-025 Step mode: step_mode=1, LDI r1,7 -> parks in WAIT_STEP until step pulse; a step pulse during EXEC is ignored.
REQ-026 Halt, illegal and reset: opcode E -> illegal=1, execution continues; HALT -> halted=1, imem_req=0; rst mid-fetch -> PC=0, fetch from address 0.
